// File: rtl/maindec_pkg.sv
// +----------------------------------------------------------------------------+
// | maindec_pkg                                                                |
// | FSM state codes, instruction classes and opcode match patterns for the     |
// | multicycle main decoder.                                                   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package maindec_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_EXC    = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_INVALID = 3'd0,
        CLS_RTYPE   = 3'd1,
        CLS_LDUR    = 3'd2,
        CLS_STUR    = 3'd3,
        CLS_CBZ     = 3'd4,
        CLS_ERET    = 3'd5,
        CLS_MRS     = 3'd6,
        CLS_BR      = 3'd7
    } class_e;

    localparam int C_OPC_W = 11;

    // Each opcode is a value/mask pair; mask bits at 0 are don't-care.
    localparam logic [10:0] C_MASK_FULL = 11'b11111111111;
    localparam logic [10:0] C_OP_RTYPE  = 11'b10101010000;
    localparam logic [10:0] C_OP_LDUR   = 11'b11111000010;
    localparam logic [10:0] C_OP_STUR   = 11'b11111000000;
    localparam logic [10:0] C_OP_CBZ    = 11'b10110100000;
    localparam logic [10:0] C_MASK_CBZ  = 11'b11111111000;
    localparam logic [10:0] C_OP_ERET   = 11'b11010110100;
    localparam logic [10:0] C_OP_MRS    = 11'b01101010100;
    localparam logic [10:0] C_MASK_MRS  = 11'b01111111111;
    localparam logic [10:0] C_OP_BR     = 11'b11010110000;

    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] val,
                                      input logic [10:0] mask);
        return ((op ^ val) & mask) == 11'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_maindec_op_classify.sv
// +----------------------------------------------------------------------------+
// | op_classify                                                                |
// | Combinational opcode-to-instruction-class decode.                          |
// | Build option: MAINDEC_EXCEPTION_EN enables ERET and MRS recognition.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module op_classify
    import maindec_pkg::*;
(
    input  logic [C_OPC_W-1:0] opc_i,
    output class_e             cls_o
);

    always_comb begin
        cls_o = CLS_INVALID;
        if (op_match(opc_i, C_OP_RTYPE, C_MASK_FULL)) begin
            cls_o = CLS_RTYPE;
        end else if (op_match(opc_i, C_OP_LDUR, C_MASK_FULL)) begin
            cls_o = CLS_LDUR;
        end else if (op_match(opc_i, C_OP_STUR, C_MASK_FULL)) begin
            cls_o = CLS_STUR;
        end else if (op_match(opc_i, C_OP_CBZ, C_MASK_CBZ)) begin
            cls_o = CLS_CBZ;
        end else if (op_match(opc_i, C_OP_BR, C_MASK_FULL)) begin
            cls_o = CLS_BR;
`ifdef MAINDEC_EXCEPTION_EN
        end else if (op_match(opc_i, C_OP_ERET, C_MASK_FULL)) begin
            cls_o = CLS_ERET;
        end else if (op_match(opc_i, C_OP_MRS, C_MASK_MRS)) begin
            cls_o = CLS_MRS;
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/mc_maindec.sv
// +----------------------------------------------------------------------------+
// | mc_maindec                                                                 |
// | Multicycle main decoder: Moore control FSM plus retired-instruction count. |
// | Build option: MAINDEC_EXCEPTION_EN adds EXC state, ERET/MRS, mem timeout.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mc_maindec
    import maindec_pkg::*;
#(
    parameter int OP_W   = 11,
    parameter int CNT_W  = 32,
    parameter int MEM_TO = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  Op,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             Reg2Loc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Branch,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [1:0]       ALUSrc,
    output logic [1:0]       ALUOp,
    output logic             ERet,
    output logic             NotAnInstr,
    output logic             InconBranch,
    output logic             MemTimeout,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = $clog2(MEM_TO + 1);

    state_e             state_q, state_d;
    class_e             cls_q, cls_d, cls_w;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   retired_q;
    logic               retire_w;

    op_classify u_op_classify (
        .opc_i (Op[OP_W-1 -: C_OPC_W]),
        .cls_o (cls_w)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            cls_q     <= CLS_INVALID;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            wait_q  <= wait_d;
            if (retire_w) begin
                retired_q <= retired_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        wait_d   = wait_q;
        retire_w = 1'b0;
        {Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, IRWrite, PCWrite} = '0;
        {ALUSrc, ALUOp} = '0;
        {ERet, NotAnInstr, InconBranch, MemTimeout} = '0;

        case (state_q)
            ST_FETCH: begin
                IRWrite = 1'b1;
                if (imem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                cls_d   = cls_w;
                state_d = ST_EXEC;
`ifdef MAINDEC_EXCEPTION_EN
                if (cls_w == CLS_INVALID) state_d = ST_EXC;
`endif
            end
            ST_EXEC: begin
                state_d = ST_WB;
                case (cls_q)
                    CLS_RTYPE: ALUOp = 2'b10;
                    CLS_LDUR, CLS_STUR: begin
                        ALUSrc  = 2'b01;
                        wait_d  = '0;
                        state_d = ST_MEM;
                    end
                    CLS_CBZ: begin
                        Reg2Loc  = 1'b1;
                        ALUOp    = 2'b01;
                        Branch   = 1'b1;
                        PCWrite  = 1'b1;
                        retire_w = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    CLS_ERET: begin
`ifdef MAINDEC_EXCEPTION_EN
                        ERet     = 1'b1;
`endif
                        Branch   = 1'b1;
                        ALUOp    = 2'b01;
                        PCWrite  = 1'b1;
                        retire_w = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    CLS_MRS: begin
                        Reg2Loc = 1'b1;
                        ALUSrc  = 2'b10;
                        ALUOp   = 2'b01;
                    end
                    CLS_BR: begin
                        InconBranch = 1'b1;
                        ALUOp       = 2'b01;
                    end
                    default: begin
                        // Unrecognised opcode retires as a NOP.
                        PCWrite  = 1'b1;
                        retire_w = 1'b1;
                        state_d  = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                ALUSrc = 2'b01;
                if (cls_q == CLS_STUR) begin
                    MemWrite = 1'b1;
                    Reg2Loc  = 1'b1;
                end else begin
                    MemRead = 1'b1;
                end
                if (dmem_ready) begin
                    if (cls_q == CLS_STUR) begin
                        PCWrite  = 1'b1;
                        retire_w = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
`ifdef MAINDEC_EXCEPTION_EN
                    if (wait_q == WAIT_W'(MEM_TO - 1)) state_d = ST_EXC;
`endif
                end
            end
            ST_WB: begin
                RegWrite = (cls_q inside {CLS_RTYPE, CLS_LDUR, CLS_MRS, CLS_BR});
                MemtoReg = (cls_q == CLS_LDUR);
                PCWrite  = 1'b1;
                retire_w = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_EXC: begin
`ifdef MAINDEC_EXCEPTION_EN
                if (cls_q == CLS_INVALID) NotAnInstr = 1'b1;
                else                      MemTimeout = 1'b1;
`endif
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase

        if (reset) begin
            {Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, IRWrite, PCWrite} = '0;
            {ALUSrc, ALUOp} = '0;
            {ERet, NotAnInstr, InconBranch, MemTimeout} = '0;
        end
    end

    assign state   = reset ? 3'd0 : state_q;
    assign retired = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_maindec.sv
// +----------------------------------------------------------------------------+
// | tb_mc_maindec                                                              |
// | Randomised instruction-level bench for mc_maindec against a trace model.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mc_maindec;

    localparam int OPW = 11;
    localparam int CW  = 4;
    localparam int TO  = 15;
`ifdef MAINDEC_EXCEPTION_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    localparam int C_INV = 0, C_RTYPE = 1, C_LDUR = 2, C_STUR = 3,
                   C_CBZ = 4, C_ERET = 5, C_MRS = 6, C_BR = 7;

    // Control word: {Reg2Loc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,IRWrite,PCWrite,
    //                ALUSrc[1:0],ALUOp[1:0],ERet,NotAnInstr,InconBranch,MemTimeout}
    localparam logic [15:0] M_R2L = 16'h8000, M_M2R = 16'h4000, M_RW  = 16'h2000,
                            M_MR  = 16'h1000, M_MW  = 16'h0800, M_BR  = 16'h0400,
                            M_IRW = 16'h0200, M_PCW = 16'h0100, AS01  = 16'h0040,
                            AS10  = 16'h0080, AO01  = 16'h0010, AO10  = 16'h0020,
                            M_ERT = 16'h0008, M_NAI = 16'h0004, M_INC = 16'h0002,
                            M_MTO = 16'h0001;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [OPW-1:0]  Op = '0;
    logic            imem_ready = 1'b0;
    logic            dmem_ready = 1'b0;
    logic            Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, IRWrite, PCWrite;
    logic [1:0]      ALUSrc, ALUOp;
    logic            ERet, NotAnInstr, InconBranch, MemTimeout;
    logic [2:0]      state;
    logic [CW-1:0]   retired;
    logic [15:0]     got_cw;

    int n_chk = 0;
    int n_err = 0;
    int mdl_ret = 0;

    mc_maindec #(.OP_W(OPW), .CNT_W(CW), .MEM_TO(TO)) dut (
        .clk(clk), .reset(reset), .Op(Op),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .Reg2Loc(Reg2Loc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .Branch(Branch), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .ALUSrc(ALUSrc), .ALUOp(ALUOp), .ERet(ERet), .NotAnInstr(NotAnInstr),
        .InconBranch(InconBranch), .MemTimeout(MemTimeout),
        .state(state), .retired(retired)
    );

    assign got_cw = {Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, IRWrite, PCWrite,
                     ALUSrc, ALUOp, ERet, NotAnInstr, InconBranch, MemTimeout};

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Instruction class straight from the opcode table.
    function automatic int classify(input logic [10:0] o);
        casez (o)
            11'b10101010000: return C_RTYPE;
            11'b11111000010: return C_LDUR;
            11'b11111000000: return C_STUR;
            11'b10110100???: return C_CBZ;
            11'b11010110100: return EXC_EN ? C_ERET : C_INV;
            11'b?1101010100: return EXC_EN ? C_MRS : C_INV;
            11'b11010110000: return C_BR;
            default:         return C_INV;
        endcase
    endfunction

    function automatic logic [15:0] exec_cw(input int c);
        case (c)
            C_RTYPE:        return AO10;
            C_LDUR, C_STUR: return AS01;
            C_CBZ:          return M_R2L | AO01 | M_BR | M_PCW;
            C_ERET:         return M_BR | M_ERT | AO01 | M_PCW;
            C_MRS:          return M_R2L | AS10 | AO01;
            C_BR:           return M_INC | AO01;
            default:        return M_PCW;
        endcase
    endfunction

    function automatic logic [10:0] rand_op(input int pick);
        case (pick)
            0: return 11'b10101010000;
            1: return 11'b11111000010;
            2: return 11'b11111000000;
            3: return {8'b10110100, 3'($urandom)};
            4: return 11'b11010110100;
            5: return {1'($urandom), 10'b1101010100};
            6: return 11'b11010110000;
            default: return 11'($urandom);
        endcase
    endfunction

    // One clock of the expected trace: check, then advance past the edge.
    task automatic cyc(input logic [2:0] st, input logic [15:0] cw, input bit ret);
        #1;
        check_eq("state", {29'd0, state}, {29'd0, st});
        check_eq("ctl", {16'd0, got_cw}, {16'd0, cw});
        check_eq("retired", {28'd0, retired}, 32'(mdl_ret % (1 << CW)));
        @(posedge clk);
        #1;
        if (ret) mdl_ret++;
    endtask

    task automatic run_instr(input logic [10:0] opc, input int n_i, input int n_d,
                             input int rst_at);
        int c;
        bit stur;
        bit done;
        logic [15:0] mw;
        c    = classify(opc);
        stur = (c == C_STUR);
        for (int k = 0; k <= n_i; k++) begin
            imem_ready = (k == n_i);
            dmem_ready = 1'($urandom);
            Op         = OPW'($urandom);
            cyc(3'd0, M_IRW, 1'b0);
        end
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        Op         = opc;
        cyc(3'd1, 16'h0, 1'b0);
        Op = OPW'($urandom);
        if (c == C_INV && EXC_EN) begin
            cyc(3'd5, M_NAI, 1'b0);
            return;
        end
        done = (c == C_CBZ || c == C_ERET || c == C_INV);
        cyc(3'd2, exec_cw(c), done);
        if (done) return;
        if (c == C_LDUR || stur) begin
            mw = stur ? (M_MW | M_R2L | AS01) : (M_MR | AS01);
            for (int k = 0; k <= n_d; k++) begin
                if (EXC_EN && k == TO) begin
                    dmem_ready = 1'b0;
                    cyc(3'd5, M_MTO, 1'b0);
                    return;
                end
                if (k == rst_at) begin
                    reset      = 1'b1;
                    dmem_ready = 1'b1;
                    cyc(3'd0, 16'h0, 1'b0);
                    mdl_ret = 0;
                    reset   = 1'b0;
                    return;
                end
                dmem_ready = (k == n_d);
                imem_ready = 1'($urandom);
                cyc(3'd3, mw | ((k == n_d && stur) ? M_PCW : 16'h0), (k == n_d) && stur);
            end
            if (stur) return;
        end
        dmem_ready = 1'($urandom);
        cyc(3'd4, M_RW | M_PCW | ((c == C_LDUR) ? M_M2R : 16'h0), 1'b1);
    endtask

    initial begin
        int nd;
        reset      = 1'b1;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("rst_state", {29'd0, state}, 32'd0);
        check_eq("rst_ctl", {16'd0, got_cw}, 32'd0);
        check_eq("rst_retired", {28'd0, retired}, 32'd0);
        reset = 1'b0;

        run_instr(11'b10101010000, 0, 0, -1);   // RTYPE
        run_instr(11'b11111000010, 0, 3, -1);   // LDUR, 3 wait cycles
        run_instr(11'b00000000000, 1, 0, -1);   // unrecognised opcode
        run_instr(11'b11111000000, 0, 20, -1);  // STUR, long/never ready
        run_instr(11'b11111000010, 0, 14, -1);  // LDUR, just under timeout
        run_instr(11'b11010110100, 2, 0, -1);   // ERET
        run_instr(11'b01101010100, 0, 0, -1);   // MRS
        run_instr(11'b11111000010, 1, 10, 2);   // reset during MEM

        for (int i = 0; i < 16; i++) begin
            run_instr({8'b10110100, 3'($urandom)}, int'($urandom_range(0, 1)), 0, -1);
        end
        #1;
        check_eq("wrap", {28'd0, retired}, 32'd0);

        for (int i = 0; i < 200; i++) begin
            nd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 17))
                                             : int'($urandom_range(0, 4));
            run_instr(rand_op(int'($urandom_range(0, 7))), int'($urandom_range(0, 3)), nd, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mc_maindec.md
MC_MAINDEC -- requirements
Module: mc_maindec

Interface
REQ-001 Parameter OP_W, default 11: opcode field width; opcode is always bits [OP_W-1:OP_W-11].
REQ-002 Parameter CNT_W, default 32: retired-instruction counter width.
REQ-003 Parameter MEM_TO, default 15: maximum data-memory wait cycles before a timeout.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 Op  in  OP_W  opcode of the instruction currently in IR.
REQ-007 imem_ready, dmem_ready  in  1 each  fetch-done and data-access-done handshakes.
REQ-008 Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, IRWrite, PCWrite  out  1 each  datapath controls.
REQ-009 ALUSrc, ALUOp  out  2 each  ALU operand-select and operation-class controls.
REQ-010 ERet, NotAnInstr, InconBranch, MemTimeout  out  1 each  exception and branch flags.
REQ-011 state  out  3  current FSM state; retired  out  CNT_W  retired-instruction count.

Function
REQ-012 Moore FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, EXC=5; codes 6-7 SHALL go to FETCH.
REQ-013 FETCH: IRWrite=1 while waiting; on imem_ready=1 -> DECODE, otherwise stay.
REQ-014 DECODE SHALL register the instruction class from Op: RTYPE 10101010000, LDUR 11111000010, STUR 11111000000, CBZ 10110100xxx, ERET 11010110100, MRS x1101010100, BR 11010110000, otherwise INVALID; DECODE -> EXEC, or -> EXC when the class is INVALID.
REQ-015 EXEC control values per class: RTYPE ALUSrc=00, ALUOp=10; LDUR/STUR ALUSrc=01, ALUOp=00; CBZ Reg2Loc=1, ALUOp=01, Branch=1; ERET Branch=1, ERet=1, ALUOp=01; MRS Reg2Loc=1, ALUSrc=10, ALUOp=01; BR InconBranch=1, ALUOp=01.
REQ-016 EXEC next state: LDUR/STUR -> MEM; RTYPE/MRS/BR -> WB; CBZ/ERET -> FETCH with PCWrite=1 and retire.
REQ-017 MEM: LDUR asserts MemRead=1 and STUR asserts MemWrite=1 (STUR with Reg2Loc=1), both with ALUSrc=01; MemRead/MemWrite SHALL stay high until dmem_ready.
REQ-018 MEM exit on dmem_ready: LDUR -> WB; STUR -> FETCH with PCWrite=1 and retire.
REQ-019 MEM wait counter (width ceil(log2(MEM_TO+1))) SHALL clear on MEM entry and increment per waiting cycle; when it reaches MEM_TO without dmem_ready -> EXC with MemTimeout=1.
REQ-020 WB: RegWrite=1 for RTYPE/LDUR/MRS/BR; MemtoReg=1 only for LDUR; PCWrite=1; -> FETCH and retire.
REQ-021 EXC SHALL last exactly one cycle: NotAnInstr=1 for INVALID, otherwise MemTimeout=1; RegWrite, MemWrite and PCWrite SHALL stay 0; -> FETCH; the instruction SHALL NOT retire.
REQ-022 Every control not named for a state/class SHALL be 0; no output SHALL be X or Z.
REQ-023 retired SHALL increment by 1 on each retire, wrapping modulo 2^CNT_W.
REQ-024 dmem_ready and imem_ready outside MEM and FETCH respectively SHALL be ignored.

Reset
REQ-025 reset=1 at a clock edge SHALL force FETCH, class INVALID, wait counter 0 and retired 0, overriding any other event including mid-MEM.
REQ-026 While in reset all control outputs SHALL be 0, including IRWrite; state SHALL read 0.

Configuration
REQ-027 With macro MAINDEC_EXCEPTION_EN defined: ERET, MRS, INVALID->EXC and the MEM timeout SHALL all be as specified above.
REQ-028 Without MAINDEC_EXCEPTION_EN: ERET and MRS opcodes decode as INVALID; INVALID SHALL retire as a NOP via DECODE->EXEC->FETCH with PCWrite=1; EXC and the timeout SHALL be absent; NotAnInstr, ERet and MemTimeout SHALL be tied to 0.

Structure
REQ-029 Package maindec_pkg SHALL hold the state enum, the instruction-class enum and the opcode pattern constants.
REQ-030 Sub-module op_classify SHALL perform the combinational Op-to-class decode, instantiated once.

Verification
REQ-031 RTYPE 10101010000, imem_ready=1 at once -> states 0,1,2,4,0; RegWrite=1 and ALUOp=10 only in WB/EXEC; retired 0->1.
REQ-032 LDUR with dmem_ready held low 3 cycles -> MEM lasts 4 cycles with MemRead=1 throughout; WB MemtoReg=1; retired +1.
REQ-033 Op 00000000000 (macro on) -> EXC for one cycle with NotAnInstr=1 and PCWrite=0; retired unchanged. Same opcode (macro off) -> NOP retire, retired +1.
REQ-034 STUR with dmem_ready never asserted, MEM_TO=15 -> MemTimeout=1 after 15 MEM cycles; next state FETCH.
REQ-035 reset pulsed during MEM of LDUR -> next cycle state=0, MemRead=0, retired=0.
REQ-036 CNT_W=4 with 16 CBZ retires -> retired wraps to 0.
